// File: rtl/fifo_sync.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow errors, synchronous flush and selectable FWFT/registered read.
module fifo_sync #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 3,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1,
    parameter bit FWFT      = 1'b1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             push_i,
    output logic             full,
    output logic             afull,
    output logic [WIDTH-1:0] dat_o,
    input  logic             pop_i,
    output logic             empty,
    output logic             aempty,
    output logic [DEPTH:0]   count,
    output logic             ovf,
    output logic             udf
);

    localparam int PW      = DEPTH + 1;
    localparam int ENTRIES = 1 << DEPTH;
    localparam logic [PW-1:0] FULL_CNT   = PW'(ENTRIES);
    localparam logic [PW-1:0] AFULL_CNT  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_CNT = PW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [ENTRIES];
    logic [PW-1:0]    wptr, rptr;
    logic [PW-1:0]    wptr_nxt, rptr_nxt, count_nxt;
    logic             push_ok, pop_ok;

    // Accept decisions use the registered flags only, so a full FIFO never
    // takes a push even when a pop frees a slot in the same cycle.
    always_comb begin
        push_ok   = push_i && !full;
        pop_ok    = pop_i && !empty;
        wptr_nxt  = wptr + {{DEPTH{1'b0}}, push_ok};
        rptr_nxt  = rptr + {{DEPTH{1'b0}}, pop_ok};
        count_nxt = wptr_nxt - rptr_nxt;
    end

    assign count = wptr - rptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wptr   <= '0;
            rptr   <= '0;
            full   <= 1'b0;
            afull  <= 1'b0;
            empty  <= 1'b1;
            aempty <= 1'b1;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (clr_i) begin
            wptr   <= '0;
            rptr   <= '0;
            full   <= 1'b0;
            afull  <= 1'b0;
            empty  <= 1'b1;
            aempty <= 1'b1;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            wptr   <= wptr_nxt;
            rptr   <= rptr_nxt;
            // Flags come from the next-state count so they line up with count.
            full   <= (count_nxt == FULL_CNT);
            afull  <= (count_nxt >= AFULL_CNT);
            empty  <= (count_nxt == '0);
            aempty <= (count_nxt <= AEMPTY_CNT);
            if (push_i && !push_ok) ovf <= 1'b1;
            if (pop_i && !pop_ok)   udf <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; stale words are unreachable because
    // the pointers are reset, and leaving it out lets the array map to RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !clr_i) begin
            mem[wptr[DEPTH-1:0]] <= dat_i;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign dat_o = mem[rptr[DEPTH-1:0]];
        end else begin : g_reg
            logic [WIDTH-1:0] dat_q;

            always_ff @(posedge clk or posedge rst_i) begin
                if (rst_i) begin
                    dat_q <= '0;
                end else if (clr_i) begin
                    dat_q <= '0;
                end else if (pop_ok) begin
                    dat_q <= mem[rptr[DEPTH-1:0]];
                end
            end

            assign dat_o = dat_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync.sv
// Directed and model-checked bench for fifo_sync: FWFT and registered-read
// instances at DEPTH=3 sharing stimulus, plus a DEPTH=1 instance for wrap tests.
module tb_fifo_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr, push, pop, push1, pop1;
    logic [7:0] din, din1;

    logic       full_a, afull_a, empty_a, aempty_a, ovf_a, udf_a;
    logic [7:0] dout_a;
    logic [3:0] count_a;
    logic       full_b, afull_b, empty_b, aempty_b, ovf_b, udf_b;
    logic [7:0] dout_b;
    logic [3:0] count_b;
    logic       full_c, afull_c, empty_c, aempty_c, ovf_c, udf_c;
    logic [7:0] dout_c;
    logic [1:0] count_c;

    fifo_sync #(.WIDTH(8), .DEPTH(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1'b1)) u_dut (
        .clk(clk), .rst_i(rst), .clr_i(clr), .dat_i(din), .push_i(push),
        .full(full_a), .afull(afull_a), .dat_o(dout_a), .pop_i(pop),
        .empty(empty_a), .aempty(aempty_a), .count(count_a), .ovf(ovf_a), .udf(udf_a)
    );

    fifo_sync #(.WIDTH(8), .DEPTH(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1'b0)) u_reg (
        .clk(clk), .rst_i(rst), .clr_i(clr), .dat_i(din), .push_i(push),
        .full(full_b), .afull(afull_b), .dat_o(dout_b), .pop_i(pop),
        .empty(empty_b), .aempty(aempty_b), .count(count_b), .ovf(ovf_b), .udf(udf_b)
    );

    fifo_sync #(.WIDTH(8), .DEPTH(1), .AFULL_TH(2), .AEMPTY_TH(0), .FWFT(1'b1)) u_d1 (
        .clk(clk), .rst_i(rst), .clr_i(clr), .dat_i(din1), .push_i(push1),
        .full(full_c), .afull(afull_c), .dat_o(dout_c), .pop_i(pop1),
        .empty(empty_c), .aempty(aempty_c), .count(count_c), .ovf(ovf_c), .udf(udf_c)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       push, pop, clr;
        logic [7:0] din;
        logic [3:0] cnt;
        logic       full, afull, empty, aempty, ovf, udf;
        logic [7:0] dout;
        logic       chk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int p, input int q, input int c, input int d,
                                input int n, input int f, input int af, input int e,
                                input int ae, input int o, input int u, input int dd,
                                input int k);
        vec_t v;
        v.push = (p != 0); v.pop = (q != 0); v.clr = (c != 0);
        v.din = 8'(d); v.cnt = 4'(n);
        v.full = (f != 0); v.afull = (af != 0); v.empty = (e != 0); v.aempty = (ae != 0);
        v.ovf = (o != 0); v.udf = (u != 0);
        v.dout = 8'(dd); v.chk = (k != 0);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic c, input logic [7:0] d);
        @(negedge clk);
        push = p; pop = q; clr = c; din = d;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] qa[$];
    logic [7:0] qc[$];

    initial begin
        rst = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
        push1 = 1'b0; pop1 = 1'b0; din1 = '0;

        // fill / overflow / drain
        //               p q c din   n f af e ae o u dout chk
        vecs.push_back(mk(1,0,0,'h10, 1,0,0,0,1, 0,0,'h10,1));
        vecs.push_back(mk(1,0,0,'h11, 2,0,0,0,0, 0,0,'h10,1));
        vecs.push_back(mk(1,0,0,'h12, 3,0,0,0,0, 0,0,'h10,1));
        vecs.push_back(mk(1,0,0,'h13, 4,0,0,0,0, 0,0,'h10,1));
        vecs.push_back(mk(1,0,0,'h14, 5,0,0,0,0, 0,0,'h10,1));
        vecs.push_back(mk(1,0,0,'h15, 6,0,1,0,0, 0,0,'h10,1));
        vecs.push_back(mk(1,0,0,'h16, 7,0,1,0,0, 0,0,'h10,1));
        vecs.push_back(mk(1,0,0,'h17, 8,1,1,0,0, 0,0,'h10,1));
        vecs.push_back(mk(1,0,0,'hFF, 8,1,1,0,0, 1,0,'h10,1));
        vecs.push_back(mk(0,1,0,0,    7,0,1,0,0, 1,0,'h11,1));
        vecs.push_back(mk(0,1,0,0,    6,0,1,0,0, 1,0,'h12,1));
        vecs.push_back(mk(0,1,0,0,    5,0,0,0,0, 1,0,'h13,1));
        vecs.push_back(mk(0,1,0,0,    4,0,0,0,0, 1,0,'h14,1));
        vecs.push_back(mk(0,1,0,0,    3,0,0,0,0, 1,0,'h15,1));
        vecs.push_back(mk(0,1,0,0,    2,0,0,0,0, 1,0,'h16,1));
        vecs.push_back(mk(0,1,0,0,    1,0,0,0,1, 1,0,'h17,1));
        vecs.push_back(mk(0,1,0,0,    0,0,0,1,1, 1,0,0,   0));
        // pop on empty, then push+pop on empty
        vecs.push_back(mk(0,1,0,0,    0,0,0,1,1, 1,1,0,   0));
        vecs.push_back(mk(1,1,0,'h33, 1,0,0,0,1, 1,1,'h33,1));
        // flush beats a concurrent push
        vecs.push_back(mk(1,0,1,'h99, 0,0,0,1,1, 0,0,0,   0));
        vecs.push_back(mk(0,0,0,0,    0,0,0,1,1, 0,0,0,   0));
        // push+pop at count 3
        vecs.push_back(mk(1,0,0,'h41, 1,0,0,0,1, 0,0,'h41,1));
        vecs.push_back(mk(1,0,0,'h42, 2,0,0,0,0, 0,0,'h41,1));
        vecs.push_back(mk(1,0,0,'h43, 3,0,0,0,0, 0,0,'h41,1));
        vecs.push_back(mk(1,1,0,'h44, 3,0,0,0,0, 0,0,'h42,1));
        vecs.push_back(mk(1,1,0,'h45, 3,0,0,0,0, 0,0,'h43,1));
        vecs.push_back(mk(0,1,0,0,    2,0,0,0,0, 0,0,'h44,1));
        vecs.push_back(mk(0,1,0,0,    1,0,0,0,1, 0,0,'h45,1));
        vecs.push_back(mk(0,1,0,0,    0,0,0,1,1, 0,0,0,   0));
        // push+pop when full
        vecs.push_back(mk(1,0,0,'h50, 1,0,0,0,1, 0,0,'h50,1));
        vecs.push_back(mk(1,0,0,'h51, 2,0,0,0,0, 0,0,'h50,1));
        vecs.push_back(mk(1,0,0,'h52, 3,0,0,0,0, 0,0,'h50,1));
        vecs.push_back(mk(1,0,0,'h53, 4,0,0,0,0, 0,0,'h50,1));
        vecs.push_back(mk(1,0,0,'h54, 5,0,0,0,0, 0,0,'h50,1));
        vecs.push_back(mk(1,0,0,'h55, 6,0,1,0,0, 0,0,'h50,1));
        vecs.push_back(mk(1,0,0,'h56, 7,0,1,0,0, 0,0,'h50,1));
        vecs.push_back(mk(1,0,0,'h57, 8,1,1,0,0, 0,0,'h50,1));
        vecs.push_back(mk(1,1,0,'hEE, 7,0,1,0,0, 1,0,'h51,1));
        vecs.push_back(mk(0,1,0,0,    6,0,1,0,0, 1,0,'h52,1));
        vecs.push_back(mk(0,1,0,0,    5,0,0,0,0, 1,0,'h53,1));
        vecs.push_back(mk(0,1,0,0,    4,0,0,0,0, 1,0,'h54,1));
        vecs.push_back(mk(0,1,0,0,    3,0,0,0,0, 1,0,'h55,1));
        vecs.push_back(mk(0,1,0,0,    2,0,0,0,0, 1,0,'h56,1));
        vecs.push_back(mk(0,1,0,0,    1,0,0,0,1, 1,0,'h57,1));
        vecs.push_back(mk(0,1,0,0,    0,0,0,1,1, 1,0,0,   0));

        // reset state
        #1;
        check("rst count", count_a, 0);
        check("rst empty", empty_a, 1);
        check("rst aempty", aempty_a, 1);
        check("rst full", full_a, 0);
        check("rst afull", afull_a, 0);
        check("rst ovf", ovf_a, 0);
        check("rst udf", udf_a, 0);
        check("rst dout_reg", dout_b, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
            check($sformatf("v%0d count", i), count_a, vecs[i].cnt);
            check($sformatf("v%0d full", i), full_a, vecs[i].full);
            check($sformatf("v%0d afull", i), afull_a, vecs[i].afull);
            check($sformatf("v%0d empty", i), empty_a, vecs[i].empty);
            check($sformatf("v%0d aempty", i), aempty_a, vecs[i].aempty);
            check($sformatf("v%0d ovf", i), ovf_a, vecs[i].ovf);
            check($sformatf("v%0d udf", i), udf_a, vecs[i].udf);
            if (vecs[i].chk) check($sformatf("v%0d dout", i), dout_a, vecs[i].dout);
        end

        // read latency, FWFT vs registered
        step(0, 0, 1, 0);
        step(1, 0, 0, 8'hA5);
        check("lat fwft dout", dout_a, 8'hA5);
        check("lat fwft empty", empty_a, 0);
        check("lat fwft count", count_a, 1);
        check("lat reg dout", dout_b, 8'h00);
        check("lat reg empty", empty_b, 0);
        step(0, 0, 0, 0);
        check("lat reg idle", dout_b, 8'h00);
        step(0, 1, 0, 0);
        check("lat fwft pop empty", empty_a, 1);
        check("lat fwft pop count", count_a, 0);
        check("lat reg pop dout", dout_b, 8'hA5);
        check("lat reg pop empty", empty_b, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("lat reg hold", dout_b, 8'hA5);
        step(0, 1, 0, 0);
        check("lat fwft udf", udf_a, 1);
        check("lat fwft udf count", count_a, 0);
        check("lat reg udf", udf_b, 1);
        check("lat reg udf dout", dout_b, 8'hA5);
        step(1, 0, 0, 8'h01);
        step(1, 0, 0, 8'h02);
        check("lat reg no pop", dout_b, 8'hA5);
        step(0, 1, 0, 0);
        check("lat reg pop1", dout_b, 8'h01);
        step(0, 1, 0, 0);
        check("lat reg pop2", dout_b, 8'h02);
        step(0, 0, 0, 0);
        check("lat reg hold2", dout_b, 8'h02);

        // random traffic against queue models, DEPTH=3 and DEPTH=1
        step(0, 0, 1, 0);
        for (int i = 0; i < 40; i++) begin
            logic pa, pp, ca, cp;
            @(negedge clk);
            clr   = 1'b0;
            push  = ($urandom_range(0, 99) < 60);
            pop   = ($urandom_range(0, 99) < 50);
            din   = 8'($urandom);
            push1 = ($urandom_range(0, 99) < 55);
            pop1  = ($urandom_range(0, 99) < 55);
            din1  = 8'($urandom);
            pa = push  && (qa.size() < 8);
            pp = pop   && (qa.size() > 0);
            ca = push1 && (qc.size() < 2);
            cp = pop1  && (qc.size() > 0);
            if (pp) void'(qa.pop_front());
            if (pa) qa.push_back(din);
            if (cp) void'(qc.pop_front());
            if (ca) qc.push_back(din1);
            @(posedge clk);
            #1;
            check($sformatf("r%0d d3 count", i), count_a, qa.size());
            check($sformatf("r%0d d3 full", i), full_a, qa.size() == 8);
            check($sformatf("r%0d d3 empty", i), empty_a, qa.size() == 0);
            if (qa.size() > 0) check($sformatf("r%0d d3 dout", i), dout_a, qa[0]);
            check($sformatf("r%0d d1 count", i), count_c, qc.size());
            check($sformatf("r%0d d1 full", i), full_c, qc.size() == 2);
            check($sformatf("r%0d d1 empty", i), empty_c, qc.size() == 0);
            if (qc.size() > 0) check($sformatf("r%0d d1 dout", i), dout_c, qc[0]);
        end
        @(negedge clk);
        push1 = 1'b0; pop1 = 1'b0;

        // flush with pending push
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        check("flush pre udf", udf_a, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h60 + i));
        check("flush pre count", count_a, 5);
        step(1, 0, 1, 8'h77);
        check("flush count", count_a, 0);
        check("flush empty", empty_a, 1);
        check("flush ovf", ovf_a, 0);
        check("flush udf", udf_a, 0);
        step(0, 0, 0, 0);
        check("flush push ignored", count_a, 0);

        // asynchronous reset between edges
        step(1, 0, 0, 8'h80);
        step(1, 0, 0, 8'h81);
        step(1, 0, 0, 8'h82);
        step(0, 1, 0, 0);
        check("arst pre count", count_a, 2);
        check("arst pre dout_reg", dout_b, 8'h80);
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst count", count_a, 0);
        check("arst empty", empty_a, 1);
        check("arst aempty", aempty_a, 1);
        check("arst full", full_a, 0);
        check("arst afull", afull_a, 0);
        check("arst dout_reg", dout_b, 8'h00);
        #1 rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
